// File: rtl/avalon_resp_pkg.sv
// Shared definitions for the Avalon-MM sample responder.
//   OOR_DATA     : read data returned for addresses outside the buffer
//   SAMPLE_W     : width of one buffered sample (the responder DATA_W must match)
//   pipe_entry_t : one slot of the read-return delay line {valid, data}
//   word_idx_t   : result of the byte-address to word-index translation
//   word_index() : translates a byte address and performs the range check
package avalon_resp_pkg;

  localparam logic [31:0] OOR_DATA = 32'hDEADBEEF;
  localparam int          SAMPLE_W = 32;

  typedef struct packed {
    logic                valid;
    logic [SAMPLE_W-1:0] data;
  } pipe_entry_t;

  typedef struct packed {
    logic        ok;   // address decodes to a word inside the buffer
    logic [31:0] idx;  // word index, meaningful only when ok is set
  } word_idx_t;

  // All arithmetic is 64-bit so BASE + 4*DEPTH cannot overflow for any
  // address width up to 32 bits.
  function automatic word_idx_t word_index(
    input logic [63:0] addr,
    input logic [63:0] base,
    input logic [63:0] depth
  );
    word_idx_t   r;
    logic [63:0] off;
    off   = addr - base;
    r.ok  = (addr >= base) && (addr < base + (depth << 2)) && (addr[1:0] == 2'b00);
    r.idx = 32'(off >> 2);
    return r;
  endfunction

endpackage

// File: rtl/avalon_sample_responder_read_pipe.sv
// resp_read_pipe: delay line carrying read returns to the Avalon port.
//   clk, reset : clock and synchronous active-high reset
//   in_entry   : {valid, data} leaving the buffer's output register
//   out_valid  : drives readdatavalid
//   out_data   : drives readdata; holds its value through bubbles
// The buffer output register in the parent is the first stage of the total
// latency, so this module only adds LATENCY-1 stages.
module resp_read_pipe
  import avalon_resp_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  pipe_entry_t         in_entry,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_data
);

  localparam int STAGES = LATENCY - 1;

  pipe_entry_t tail;

  generate
    if (STAGES == 0) begin : g_direct
      assign tail = in_entry;
    end else begin : g_delay
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        pipe_entry_t prev;
        pipe_entry_t stage_reg;

        if (gi == 0) begin : g_first
          assign prev = in_entry;
        end else begin : g_chain
          assign prev = g_stage[gi-1].stage_reg;
        end

        // Data only moves with a valid entry, so the last stage keeps the
        // most recent return visible while readdatavalid is low.
        always_ff @(posedge clk) begin
          if (reset) begin
            stage_reg <= '0;
          end else begin
            stage_reg.valid <= prev.valid;
            if (prev.valid) begin
              stage_reg.data <= prev.data;
            end
          end
        end
      end
      assign tail = g_stage[STAGES-1].stage_reg;
    end
  endgenerate

  assign out_valid = tail.valid;
  assign out_data  = tail.data;

endmodule

// File: rtl/avalon_sample_responder.sv
// avalon_sample_responder: Avalon-MM slave standing in for the SDRAM sample
// buffer. Word-addressed on-chip RAM, fixed-latency pipelined reads,
// waitrequest backpressure on outstanding reads plus optional periodic stalls,
// and a side-load port for preloading samples.
//   clk, reset                      : clock, synchronous active-high reset
//   address, read, write, writedata : Avalon-MM request (byte address)
//   waitrequest                     : request not accepted while high
//   readdata, readdatavalid         : pipelined read return
//   load_en, load_index, load_data  : side-load word write, never stalls
//   read_count, write_count         : accepted transfers, wrap at 2^32
//   err_count                       : protocol and out-of-range errors
// DATA_W must equal avalon_resp_pkg::SAMPLE_W.
module avalon_sample_responder #(
  parameter int                ADDR_W       = 24,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                DEPTH_WORDS  = 1024,
  parameter int                READ_LATENCY = 3,
  parameter int                MAX_PENDING  = 4,
  parameter int                STALL_EVERY  = 0,
  parameter logic [DATA_W-1:0] OOR_DATA     = DATA_W'(avalon_resp_pkg::OOR_DATA)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_W-1:0]              address,
  input  logic                           read,
  input  logic                           write,
  input  logic [DATA_W-1:0]              writedata,
  output logic                           waitrequest,
  output logic [DATA_W-1:0]              readdata,
  output logic                           readdatavalid,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_index,
  input  logic [DATA_W-1:0]              load_data,
  output logic [31:0]                    read_count,
  output logic [31:0]                    write_count,
  output logic [31:0]                    err_count
);

  import avalon_resp_pkg::*;

  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int PEND_W  = $clog2(MAX_PENDING + 1);
  localparam int STALL_W = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  word_idx_t         wi;
  logic [IDX_W-1:0]  req_idx;
  logic              unused_idx_bits;
  logic              rd_accept;
  logic              wr_accept;
  logic              wr_drop;
  logic              rd_ret;

  logic              ram_we;
  logic [IDX_W-1:0]  ram_widx;
  logic [DATA_W-1:0] ram_wdata;

  logic              rd_valid_reg;
  logic              rd_oor_reg;
  logic [DATA_W-1:0] rd_data_reg;
  pipe_entry_t       stage0;

  logic [PEND_W-1:0]  pending_reg,   pending_next;
  logic               stall_reg,     stall_next;
  logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [31:0]        read_count_reg,  read_count_next;
  logic [31:0]        write_count_reg, write_count_next;
  logic [31:0]        err_count_reg,   err_count_next;

  assign wi              = word_index(64'(address), 64'(BASE_ADDR), 64'(DEPTH_WORDS));
  assign req_idx         = wi.idx[IDX_W-1:0];
  assign unused_idx_bits = ^wi.idx[31:IDX_W];

  // Depends on registers only, so the master's request never loops back.
  assign waitrequest = (pending_reg == PEND_W'(MAX_PENDING)) || stall_reg;

  // A simultaneous read and write is accepted as the read; the write is lost.
  assign rd_accept = read && !waitrequest;
  assign wr_accept = write && !read && !waitrequest;
  assign wr_drop   = write && read && !waitrequest;
  assign rd_ret    = readdatavalid;

  // Single write port: an accepted in-range Avalon write takes it, otherwise
  // the side-load strobe does.
  always_comb begin
    ram_we    = 1'b0;
    ram_widx  = load_index;
    ram_wdata = load_data;
    if (!reset && wr_accept && wi.ok) begin
      ram_we    = 1'b1;
      ram_widx  = req_idx;
      ram_wdata = writedata;
    end else if (load_en) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_widx] <= ram_wdata;
    end
  end

  // Registered buffer read, sampled at the acceptance edge; it is the first
  // stage of the read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
      rd_oor_reg   <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_valid_reg <= rd_accept;
      if (rd_accept) begin
        rd_data_reg <= mem[req_idx];
        rd_oor_reg  <= !wi.ok;
      end
    end
  end

  always_comb begin
    stage0.valid = rd_valid_reg;
    stage0.data  = rd_oor_reg ? OOR_DATA : rd_data_reg;
  end

  resp_read_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_read_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_entry  (stage0),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

  always_comb begin
    pending_next     = pending_reg + PEND_W'(rd_accept) - PEND_W'(rd_ret);
    stall_next       = 1'b0;
    stall_cnt_next   = stall_cnt_reg;
    read_count_next  = read_count_reg  + 32'(rd_accept);
    write_count_next = write_count_reg + 32'(wr_accept);
    err_count_next   = err_count_reg + 32'(wr_drop)
                     + 32'(rd_accept && !wi.ok) + 32'(wr_accept && !wi.ok);
    // The Nth transfer wraps the counter and forces one waitrequest cycle.
    if (STALL_EVERY > 0 && (rd_accept || wr_accept)) begin
      if (stall_cnt_reg == STALL_W'(STALL_EVERY - 1)) begin
        stall_cnt_next = '0;
        stall_next     = 1'b1;
      end else begin
        stall_cnt_next = stall_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg     <= '0;
      stall_reg       <= 1'b0;
      stall_cnt_reg   <= '0;
      read_count_reg  <= '0;
      write_count_reg <= '0;
      err_count_reg   <= '0;
    end else begin
      pending_reg     <= pending_next;
      stall_reg       <= stall_next;
      stall_cnt_reg   <= stall_cnt_next;
      read_count_reg  <= read_count_next;
      write_count_reg <= write_count_next;
      err_count_reg   <= err_count_next;
    end
  end

  assign read_count  = read_count_reg;
  assign write_count = write_count_reg;
  assign err_count   = err_count_reg;

endmodule

// File: tb/tb_avalon_sample_responder.sv
// Self-checking bench for avalon_sample_responder. Stimulus drives the bus
// just after the rising edge; a monitor on the falling edge keeps a reference
// model (sample memory, outstanding-read queue, transfer/stall bookkeeping,
// counters) and checks every read return against the queue it fills.
// MAX_PENDING is set below READ_LATENCY so outstanding-read backpressure is
// actually reachable with single-cycle acceptance.
module tb_avalon_sample_responder;

  localparam int          ADDR_W = 24;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 1024;
  localparam int          LAT    = 3;
  localparam int          MAXP   = 2;
  localparam int          STALLN = 3;
  localparam logic [31:0] OOR    = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              load_en;
  logic [9:0]        load_index;
  logic [DATA_W-1:0] load_data;
  logic [31:0]       read_count;
  logic [31:0]       write_count;
  logic [31:0]       err_count;

  always #5 clk = ~clk;

  avalon_sample_responder #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .BASE_ADDR    ('0),
    .DEPTH_WORDS  (DEPTH),
    .READ_LATENCY (LAT),
    .MAX_PENDING  (MAXP),
    .STALL_EVERY  (STALLN),
    .OOR_DATA     (OOR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .load_en       (load_en),
    .load_index    (load_index),
    .load_data     (load_data),
    .read_count    (read_count),
    .write_count   (write_count),
    .err_count     (err_count)
  );

  typedef struct {
    logic [31:0] data;
    logic [23:0] addr;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl_mem [DEPTH];
  int          mdl_rd, mdl_wr, mdl_err;
  int          xfer_cnt;
  bit          stall_due;
  int          cyc;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_range(input logic [23:0] a);
    int ai;
    ai = int'(a);
    return (ai < 4 * DEPTH) && (ai % 4 == 0);
  endfunction

  // Reference model and scoreboard, evaluated mid-cycle when all DUT inputs
  // and outputs are stable.
  initial begin
    exp_t e;
    bit   ok;
    int   idx;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        sb_q.delete();
        mdl_rd = 0; mdl_wr = 0; mdl_err = 0;
        xfer_cnt = 0; stall_due = 0;
        if (load_en) mdl_mem[load_index] = load_data;
      end else begin
        check("waitrequest", 32'(waitrequest), 32'((sb_q.size() == MAXP) || stall_due));
        stall_due = 0;
        if (readdatavalid === 1'b1) begin
          if (sb_q.size() == 0) begin
            check("unexpected_valid", 32'(readdatavalid), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("readdata", readdata, e.data);
            check("latency", 32'(cyc - e.cyc), 32'(LAT));
            $display("rd  addr=%h data=%h cycle=%0d", e.addr, readdata, cyc);
          end
        end
        ok  = in_range(address);
        idx = int'(address) / 4;
        if (!waitrequest && (read || write)) begin
          xfer_cnt++;
          if (xfer_cnt == STALLN) begin
            xfer_cnt  = 0;
            stall_due = 1;
          end
          if (read) begin
            e.data = ok ? mdl_mem[idx] : OOR;
            e.addr = address;
            e.cyc  = cyc;
            sb_q.push_back(e);
            check("outstanding_le_max", 32'(sb_q.size() <= MAXP), 32'd1);
            mdl_rd++;
            if (!ok) mdl_err++;
            if (write) mdl_err++;
          end else begin
            mdl_wr++;
            if (!ok) mdl_err++;
            $display("wr  addr=%h data=%h in_range=%0d cycle=%0d", address, writedata, ok, cyc);
          end
        end
        if (load_en) mdl_mem[load_index] = load_data;
        if (!waitrequest && write && !read && ok) mdl_mem[idx] = writedata;
      end
    end
  end

  // Presents one request and holds it until the DUT accepts it; returns just
  // after the accepting edge with the request still driven.
  task automatic bus_req(input bit rd, input bit wr, input logic [23:0] a, input logic [31:0] d);
    bit acc;
    read = rd; write = wr; address = a; writedata = d;
    acc = 0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = !waitrequest;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    read = 0; write = 0; load_en = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_read_count"},  read_count,  32'(mdl_rd));
    check({tag, "_write_count"}, write_count, 32'(mdl_wr));
    check({tag, "_err_count"},   err_count,   32'(mdl_err));
  endtask

  initial begin
    logic [23:0] a;
    int          kind;
    reset = 1; read = 0; write = 0; address = '0; writedata = '0;
    load_en = 0; load_index = '0; load_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    check("rst_waitrequest",   32'(waitrequest),   32'd0);
    check("rst_readdatavalid", 32'(readdatavalid), 32'd0);
    check("rst_readdata",      readdata,           32'd0);
    check("rst_read_count",    read_count,         32'd0);
    check("rst_write_count",   write_count,        32'd0);
    check("rst_err_count",     err_count,          32'd0);

    // Preload the whole buffer, then the known samples 10/20/30/40.
    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1; load_index = 10'(i); load_data = $urandom;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 4; i++) begin
      load_en = 1; load_index = 10'(i); load_data = 32'((i + 1) * 10);
      @(posedge clk);
      #1;
    end
    load_en = 0;

    for (int i = 0; i < 4; i++) bus_req(1, 0, 24'(i * 4), 32'd0);
    idle(8);
    check("s1_read_count", read_count, 32'd4);

    bus_req(0, 1, 24'h40, 32'h12345678);
    bus_req(1, 0, 24'h40, 32'd0);
    idle(8);
    check("s2_write_count", write_count, 32'd1);

    bus_req(1, 0, 24'h1000, 32'd0);
    bus_req(0, 1, 24'h2, 32'hCAFEF00D);
    idle(8);
    check("s3_err_count", err_count, 32'd2);
    check_counters("s3");

    // Continuous reads exercise the stall cadence and backpressure.
    for (int i = 0; i < 12; i++) bus_req(1, 0, 24'(i * 4), 32'd0);
    idle(8);
    check_counters("burst");

    // Free-running random traffic, including illegal combinations.
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 9))
        0:       a = 24'(32'h1000 + ($urandom_range(0, 255) << 2));
        1:       a = 24'(($urandom_range(0, 63) << 2) | $urandom_range(1, 3));
        default: a = 24'($urandom_range(0, 63) << 2);
      endcase
      address   = a;
      writedata = $urandom;
      read      = (kind <= 3) || (kind == 7);
      write     = (kind >= 4) && (kind <= 7);
      load_en   = !write && ($urandom_range(0, 4) == 0);
      load_index = 10'($urandom_range(0, 63));
      load_data  = $urandom;
      @(posedge clk);
      #1;
    end
    idle(10);
    check_counters("random");

    // Reset with reads in flight: their returns must never appear.
    bus_req(1, 0, 24'h0, 32'd0);
    bus_req(1, 0, 24'h4, 32'd0);
    read = 0;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    check("mid_rst_read_count",  read_count,  32'd0);
    check("mid_rst_write_count", write_count, 32'd0);
    check("mid_rst_err_count",   err_count,   32'd0);
    idle(8);
    bus_req(1, 0, 24'h0, 32'd0);
    bus_req(1, 0, 24'h40, 32'd0);
    idle(2);

    for (int n = 0; n < 30 && sb_q.size() != 0; n++) idle(1);
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    check_counters("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
